seq_mult_ctrl: RTL and testbench

Sequential unsigned multiplier controller. It time-multiplexes a single row of WIDTH one-bit multiplier cells (AND partial product plus full-add, carry rippling cell-to-cell) over successive clock cycles, one multiplier bit per cycle, instead of instantiating the full WIDTH×WIDTH array. It sits between a requester and the shared multiplier row, providing a start/ready/done handshake and a registered 2·WIDTH-bit product.

---
 rtl/seq_mult_ctrl.sv | 115 +++++++++++
 tb/tb_seq_mult_ctrl.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/seq_mult_ctrl.sv
// seq_mult_ctrl: sequential unsigned multiplier controller.
// A single row of WIDTH adder cells is reused once per multiplier bit, with
// LSB first. Accumulator {acc_hi, acc_lo} shifts right one bit per iteration.
// Optional feature macro: SEQ_MULT_EARLY_TERM_EN. When it is defined, RUN ends
// as soon as no set multiplier bits remain.
// Handshake: start is accepted on a rising edge where ready=1. done pulses for
// one cycle with product valid. start seen while ready=0 is dropped.
`timescale 1ns/1ps
module seq_mult_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 ready,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CW = $clog2(WIDTH);
    localparam int PW = 2 * WIDTH;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state, next_state;
    logic [WIDTH-1:0]  a_r, b_r;
    logic [WIDTH:0]    acc_hi;
    logic [WIDTH-1:0]  acc_lo;
    logic [CW-1:0]     cnt;

    logic [WIDTH:0]    s;
    logic              last_iter;
    logic [CW:0]       shamt;
    logic [PW-1:0]     aligned;

    // Shared row: add the gated multiplicand to the upper accumulator half.
    // acc_hi[WIDTH] stays zero after every shift, so including it is harmless.
    always_comb begin
        s = acc_hi + (b_r[cnt] ? {1'b0, a_r} : '0);
    end

    // Final-iteration detection and alignment of the result as if every
    // remaining shift had already taken place.
    always_comb begin
`ifdef SEQ_MULT_EARLY_TERM_EN
        last_iter = (cnt == LAST) || (((b_r >> cnt) >> 1) == '0);
`else
        last_iter = (cnt == LAST);
`endif
        shamt   = (CW+1)'(WIDTH) - {1'b0, cnt};
        aligned = PW'({s, acc_lo} >> shamt);
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // Next-state and handshake outputs.
    always_comb begin
        next_state = state;
        ready      = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (start) next_state = RUN;
            end
            RUN: begin
                if (last_iter) next_state = DONE;
            end
            DONE: begin
                done       = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Datapath: operand capture, shift-accumulate, and product register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_r     <= '0;
            b_r     <= '0;
            acc_hi  <= '0;
            acc_lo  <= '0;
            cnt     <= '0;
            product <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_r    <= a;
                        b_r    <= b;
                        acc_hi <= '0;
                        acc_lo <= '0;
                        cnt    <= '0;
                    end
                end
                RUN: begin
                    acc_hi <= {1'b0, s[WIDTH:1]};
                    acc_lo <= {s[0], acc_lo[WIDTH-1:1]};
                    cnt    <= cnt + CW'(1);
                    if (last_iter) product <= aligned;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_mult_ctrl.sv
// Directed testbench for seq_mult_ctrl (WIDTH=8). Latency expectations follow
// SEQ_MULT_EARLY_TERM_EN when the bench is built with that macro.
`timescale 1ns/1ps
module tb_seq_mult_ctrl;

    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           start = 1'b0;
    logic [W-1:0]   a = '0;
    logic [W-1:0]   b = '0;
    logic           ready;
    logic           done;
    logic [2*W-1:0] product;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int done_seen = 0;

    seq_mult_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .ready(ready), .done(done), .product(product)
    );

    // Clock and cycle counter.
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Count done pulses, sampled away from the active edge.
    always @(negedge clk) if (done === 1'b1) done_seen = done_seen + 1;

    // Edges from accept to done for a given multiplier.
    function automatic int exp_lat(input logic [W-1:0] bv);
`ifdef SEQ_MULT_EARLY_TERM_EN
        int k = 0;
        for (int i = 0; i < W; i++) if (bv[i]) k = i + 1;
        return (k == 0) ? 1 : k;
`else
        return W;
`endif
    endfunction

    // Driver: called at #1 after an edge with ready=1. Issues one start
    // pulse, then waits for done (bounded). Returns latency in edges after
    // the accepting edge, the product, and whether ready stayed low.
    task automatic do_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                         output int lat, output logic [2*W-1:0] prod,
                         output logic ready_low_ok, output logic timed_out);
        a = av; b = bv; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a = W'($urandom_range(0, 255));
        b = W'($urandom_range(0, 255));
        lat = 0; prod = '0; ready_low_ok = 1'b1; timed_out = 1'b1;
        while (lat <= 40) begin
            if (ready !== 1'b0) ready_low_ok = 1'b0;
            if (done === 1'b1) begin
                timed_out = 1'b0;
                prod = product;
                break;
            end
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready got=%b exp=1", ready); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done got=%b exp=0", done); end
        n_cmp++; if (product !== 16'd0) begin n_bad++; $display("FAIL reset_product got=%0d exp=0", product); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        int lat; logic [2*W-1:0] p; logic rl, to;
        do_op(8'd13, 8'd11, lat, p, rl, to);
        n_cmp++; if (to || p !== 16'd143) begin n_bad++; $display("FAIL basic_product got=%0d exp=143 timeout=%b", p, to); end
        n_cmp++; if (lat != exp_lat(8'd11)) begin n_bad++; $display("FAIL basic_latency got=%0d exp=%0d", lat, exp_lat(8'd11)); end
        n_cmp++; if (rl !== 1'b1) begin n_bad++; $display("FAIL basic_ready_low got=%b exp=1", rl); end
        @(posedge clk); #1;
        n_cmp++; if (ready !== 1'b1 || done !== 1'b0) begin n_bad++; $display("FAIL basic_ready_return ready=%b done=%b exp ready=1 done=0", ready, done); end
    endtask

    task automatic test_corners();
        logic [W-1:0]   av [3] = '{8'd255, 8'd0, 8'd200};
        logic [W-1:0]   bv [3] = '{8'd255, 8'd200, 8'd0};
        logic [2*W-1:0] ev [3] = '{16'd65025, 16'd0, 16'd0};
        int lat; logic [2*W-1:0] p; logic rl, to;
        for (int j = 0; j < 3; j++) begin
            do_op(av[j], bv[j], lat, p, rl, to);
            n_cmp++; if (to || p !== ev[j]) begin n_bad++; $display("FAIL corner_product[%0d] got=%0d exp=%0d timeout=%b", j, p, ev[j], to); end
            n_cmp++; if (lat != exp_lat(bv[j])) begin n_bad++; $display("FAIL corner_latency[%0d] got=%0d exp=%0d", j, lat, exp_lat(bv[j])); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_ignore_start();
        done_seen = 0;
        a = 8'd6; b = 8'd199; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        a = 8'd9; b = 8'd9; start = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        start = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        n_cmp++; if (done_seen != 1) begin n_bad++; $display("FAIL ignore_done_count got=%0d exp=1", done_seen); end
        n_cmp++; if (product !== 16'd1194) begin n_bad++; $display("FAIL ignore_product got=%0d exp=1194", product); end
    endtask

    task automatic test_reset_mid();
        int lat; logic [2*W-1:0] p; logic rl, to;
        a = 8'd7; b = 8'd9; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        done_seen = 0;
        rst = 1'b1;
        #1;
        n_cmp++; if (ready !== 1'b1) begin n_bad++; $display("FAIL rstmid_ready got=%b exp=1", ready); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL rstmid_done got=%b exp=0", done); end
        n_cmp++; if (product !== 16'd0) begin n_bad++; $display("FAIL rstmid_product got=%0d exp=0", product); end
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        n_cmp++; if (done_seen != 0) begin n_bad++; $display("FAIL rstmid_no_done got=%0d exp=0", done_seen); end
        do_op(8'd3, 8'd5, lat, p, rl, to);
        n_cmp++; if (to || p !== 16'd15) begin n_bad++; $display("FAIL rstmid_next_product got=%0d exp=15 timeout=%b", p, to); end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        logic [W-1:0]   av [3] = '{8'd2, 8'd4, 8'd255};
        logic [W-1:0]   bv [3] = '{8'd3, 8'd5, 8'd1};
        logic [2*W-1:0] ev [3] = '{16'd6, 16'd20, 16'd255};
        int t [3];
        int n;
        start = 1'b1;
        for (int j = 0; j < 3; j++) begin
            a = av[j]; b = bv[j];
            @(posedge clk); #1;
            n = 0;
            while (done !== 1'b1 && n < 40) begin
                @(posedge clk); #1;
                n++;
            end
            t[j] = cyc;
            n_cmp++; if (done !== 1'b1 || product !== ev[j]) begin n_bad++; $display("FAIL b2b_product[%0d] got=%0d exp=%0d done=%b", j, product, ev[j], done); end
            if (j == 2) start = 1'b0;
            @(posedge clk); #1;
        end
        for (int j = 1; j < 3; j++) begin
            n_cmp++; if (t[j] - t[j-1] != exp_lat(bv[j]) + 2) begin n_bad++; $display("FAIL b2b_spacing[%0d] got=%0d exp=%0d", j, t[j] - t[j-1], exp_lat(bv[j]) + 2); end
        end
    endtask

    task automatic test_early_term();
        logic [W-1:0]   bv [2] = '{8'h80, 8'h01};
        logic [2*W-1:0] ev [2] = '{16'h5500, 16'h00AA};
        int lat; logic [2*W-1:0] p; logic rl, to;
        for (int j = 0; j < 2; j++) begin
            do_op(8'hAA, bv[j], lat, p, rl, to);
            n_cmp++; if (to || p !== ev[j]) begin n_bad++; $display("FAIL early_product[%0d] got=%h exp=%h timeout=%b", j, p, ev[j], to); end
            n_cmp++; if (lat != exp_lat(bv[j])) begin n_bad++; $display("FAIL early_latency[%0d] got=%0d exp=%0d", j, lat, exp_lat(bv[j])); end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_corners();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
        test_early_term();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
